// File: rtl/nbit_mosi_spi_buffer_combined.sv
// Write-only SPI master with a parallel byte buffer for the SSD1331 OLED.
// A start request latches up to N bytes plus a D/C flag per byte, then the
// first n bytes are shifted out MSB-first, one bit per clock, with chip
// select held low for the whole burst. A start request in the last bit of
// a burst chains the next burst with no idle gap.
//
// Control handshake: there is no ready signal. i_START is a one-cycle
// request honoured only in IDLE, or in the cycle carrying bit 0 of the
// last byte of a burst (o_MOSI_FINAL_BYTE=1); at any other time it is
// ignored. A request with i_N_transmit=0 is always ignored.
module nbit_mosi_spi_buffer_combined #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic               i_SCK,
    input  logic               i_RST,
    input  logic [WIDTH*N-1:0] i_DATA,
    input  logic [N-1:0]       i_DC,
    input  logic               i_START,
    input  logic [4:0]         i_N_transmit,
    output logic               o_MOSI,
    output logic               o_CS,
    output logic               o_DC,
    output logic               o_MOSI_FINAL_BIT,
    output logic               o_MOSI_FINAL_BYTE
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [4:0]       N_MAX   = 5'(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] buf_q [N];
    logic [WIDTH-1:0] buf_d [N];
    logic [N-1:0]     dcbuf_q, dcbuf_d;
    logic [IDX_W-1:0] last_q, last_d;     // index of the final byte of the burst
    logic [IDX_W-1:0] byte_q, byte_d;
    logic [BIT_W-1:0] bit_q, bit_d;

    logic mosi_q, mosi_d;
    logic cs_q, cs_d;
    logic dc_out_q, dc_out_d;
    logic fbit_q, fbit_d;
    logic fbyte_q, fbyte_d;

    logic       load;
    logic [4:0] n_clamped;
    logic       shift_d;

    assign load      = i_START && (i_N_transmit != 5'd0);
    assign n_clamped = (i_N_transmit > N_MAX) ? N_MAX : i_N_transmit;

    // State register: reset wins over everything, including a pending start.
    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter and buffer logic; outputs are derived from the
    // next-state values so that every pin comes straight from a flop.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        dcbuf_d = dcbuf_q;
        last_d  = last_q;
        byte_d  = byte_q;
        bit_d   = bit_q;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_q != '0) begin
                    bit_d = bit_q - BIT_ONE;
                end else if (byte_q != last_q) begin
                    byte_d = byte_q + IDX_ONE;
                    bit_d  = BIT_TOP;
                end else if (!load) begin
                    state_d = IDLE;
                    byte_d  = '0;
                    bit_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load is honoured in IDLE, or in the final bit of the burst.
        if (load && ((state_q == IDLE) ||
                     ((bit_q == '0) && (byte_q == last_q)))) begin
            for (int k = 0; k < N; k++) begin
                buf_d[k] = i_DATA[k*WIDTH +: WIDTH];
            end
            dcbuf_d = i_DC;
            last_d  = IDX_W'(n_clamped - 5'd1);
            byte_d  = '0;
            bit_d   = BIT_TOP;
        end

        shift_d  = (state_d == SHIFT);
        cs_d     = !shift_d;
        mosi_d   = shift_d && buf_d[byte_d][bit_d];
        dc_out_d = shift_d && dcbuf_d[byte_d];
        fbit_d   = shift_d && (bit_d == '0);
        fbyte_d  = fbit_d && (byte_d == last_d);
    end

    // Datapath and output registers.
    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= '0;
            end
            dcbuf_q  <= '0;
            last_q   <= '0;
            byte_q   <= '0;
            bit_q    <= '0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
            dc_out_q <= 1'b0;
            fbit_q   <= 1'b0;
            fbyte_q  <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            dcbuf_q  <= dcbuf_d;
            last_q   <= last_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
            dc_out_q <= dc_out_d;
            fbit_q   <= fbit_d;
            fbyte_q  <= fbyte_d;
        end
    end

    assign o_MOSI            = mosi_q;
    assign o_CS              = cs_q;
    assign o_DC              = dc_out_q;
    assign o_MOSI_FINAL_BIT  = fbit_q;
    assign o_MOSI_FINAL_BYTE = fbyte_q;

endmodule

// File: tb/tb_nbit_mosi_spi_buffer_combined.sv
// Directed bench for the SPI MOSI byte-buffer master.
module tb_nbit_mosi_spi_buffer_combined;

    localparam int WIDTH = 8;
    localparam int N     = 8;

    logic               clk;
    logic               rst;
    logic [WIDTH*N-1:0] data;
    logic [N-1:0]       dc;
    logic               start;
    logic [4:0]         n_tx;
    logic               mosi, cs, dc_o, fbit, fbyte;

    int errors;
    int checks;

    logic [7:0] exp_b [8];
    logic [7:0] exp_dc;

    nbit_mosi_spi_buffer_combined #(.WIDTH(WIDTH), .N(N)) dut (
        .i_SCK             (clk),
        .i_RST             (rst),
        .i_DATA            (data),
        .i_DC              (dc),
        .i_START           (start),
        .i_N_transmit      (n_tx),
        .o_MOSI            (mosi),
        .o_CS              (cs),
        .o_DC              (dc_o),
        .o_MOSI_FINAL_BIT  (fbit),
        .o_MOSI_FINAL_BYTE (fbyte)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data = '0; dc = '0; n_tx = 5'd0;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({cs, mosi, dc_o, fbit, fbyte} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got cs,mosi,dc,fb,fB=%b required 10000",
                         c, {cs, mosi, dc_o, fbit, fbyte});
            end
        end
    endtask

    // 8-byte burst; in its final bit a chained 4-byte burst is requested.
    task automatic test_burst8();
        int pulses;
        data = 64'h7FBF_DFEF_F7FB_FDFE; dc = 8'b10101010; n_tx = 5'd8; start = 1'b1;
        exp_b[0] = 8'hFE; exp_b[1] = 8'hFD; exp_b[2] = 8'hFB; exp_b[3] = 8'hF7;
        exp_b[4] = 8'hEF; exp_b[5] = 8'hDF; exp_b[6] = 8'hBF; exp_b[7] = 8'h7F;
        exp_dc = 8'b10101010;
        pulses = 0;
        tick();
        start = 1'b0;
        data = 64'h1234_5678_9ABC_DEF0;  // must not disturb the latched buffer
        dc = 8'h55;
        for (int c = 0; c < 64; c++) begin
            checks++;
            if (cs !== 1'b0) begin
                errors++;
                $display("FAIL b8_cs cycle %0d: got %b required 0", c, cs);
            end
            checks++;
            if (mosi !== exp_b[c/8][7 - (c % 8)]) begin
                errors++;
                $display("FAIL b8_mosi cycle %0d: got %b required %b", c, mosi, exp_b[c/8][7 - (c % 8)]);
            end
            checks++;
            if (dc_o !== exp_dc[c/8]) begin
                errors++;
                $display("FAIL b8_dc cycle %0d: got %b required %b", c, dc_o, exp_dc[c/8]);
            end
            checks++;
            if (fbit !== ((c % 8) == 7)) begin
                errors++;
                $display("FAIL b8_finalbit cycle %0d: got %b required %b", c, fbit, (c % 8) == 7);
            end
            checks++;
            if (fbyte !== (c == 63)) begin
                errors++;
                $display("FAIL b8_finalbyte cycle %0d: got %b required %b", c, fbyte, c == 63);
            end
            if (fbit === 1'b1) pulses++;
            if (c == 63) begin
                data = 64'h0000_0000_C030_0C03; dc = 8'b00001100; n_tx = 5'd4; start = 1'b1;
            end
            tick();
        end
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL b8_pulse_count: got %0d required 8", pulses);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b0;
        exp_b[0] = 8'h03; exp_b[1] = 8'h0C; exp_b[2] = 8'h30; exp_b[3] = 8'hC0;
        exp_dc = 8'b00001100;
        for (int c = 0; c < 32; c++) begin
            if (c == 10) start = 1'b1;  // mid-burst request is ignored
            if (c == 11) start = 1'b0;
            checks++;
            if (cs !== 1'b0) begin
                errors++;
                $display("FAIL b2b_cs cycle %0d: got %b required 0", c, cs);
            end
            checks++;
            if (mosi !== exp_b[c/8][7 - (c % 8)]) begin
                errors++;
                $display("FAIL b2b_mosi cycle %0d: got %b required %b", c, mosi, exp_b[c/8][7 - (c % 8)]);
            end
            checks++;
            if (dc_o !== exp_dc[c/8]) begin
                errors++;
                $display("FAIL b2b_dc cycle %0d: got %b required %b", c, dc_o, exp_dc[c/8]);
            end
            checks++;
            if (fbyte !== (c == 31)) begin
                errors++;
                $display("FAIL b2b_finalbyte cycle %0d: got %b required %b", c, fbyte, c == 31);
            end
            tick();
        end
        checks++;
        if ({cs, mosi, dc_o, fbit, fbyte} !== 5'b10000) begin
            errors++;
            $display("FAIL b2b_end: got %b required 10000", {cs, mosi, dc_o, fbit, fbyte});
        end
    endtask

    task automatic test_gap_two_bytes();
        logic [15:0] exp_bits;
        exp_bits = 16'b00000011_00001100;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({cs, fbit} !== 2'b10) begin
                errors++;
                $display("FAIL gap_idle cycle %0d: got cs,fb=%b required 10", c, {cs, fbit});
            end
        end
        data = 64'h0000_0000_0000_0C03; dc = 8'b00000010; n_tx = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            checks++;
            if ({cs, mosi} !== {1'b0, exp_bits[15 - c]}) begin
                errors++;
                $display("FAIL two_mosi cycle %0d: got cs,mosi=%b required 0%b", c, {cs, mosi}, exp_bits[15 - c]);
            end
            checks++;
            if (dc_o !== (c >= 8)) begin
                errors++;
                $display("FAIL two_dc cycle %0d: got %b required %b", c, dc_o, c >= 8);
            end
            tick();
        end
        checks++;
        if ({cs, mosi, dc_o, fbit, fbyte} !== 5'b10000) begin
            errors++;
            $display("FAIL two_end: got %b required 10000", {cs, mosi, dc_o, fbit, fbyte});
        end
    endtask

    task automatic test_zero_and_clamp();
        int pulses;
        int fbytes;
        data = 64'h0102_0408_1020_4080; dc = 8'hFF; n_tx = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({cs, fbit, fbyte} !== 3'b100) begin
                errors++;
                $display("FAIL zero_n cycle %0d: got cs,fb,fB=%b required 100", c, {cs, fbit, fbyte});
            end
            tick();
        end
        n_tx = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        fbytes = 0;
        for (int c = 0; c < 64; c++) begin
            checks++;
            if (cs !== 1'b0) begin
                errors++;
                $display("FAIL clamp_cs cycle %0d: got %b required 0", c, cs);
            end
            if (fbit === 1'b1) pulses++;
            if (fbyte === 1'b1) fbytes++;
            tick();
        end
        checks++;
        if (cs !== 1'b1) begin
            errors++;
            $display("FAIL clamp_end_cs: got %b required 1", cs);
        end
        checks++;
        if (pulses != 8 || fbytes != 1) begin
            errors++;
            $display("FAIL clamp_pulses: got bits=%0d bytes=%0d required 8 and 1", pulses, fbytes);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] first;
        data = {8{8'hFF}}; dc = 8'hFF; n_tx = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        checks++;
        if ({cs, mosi, dc_o, fbit, fbyte} !== 5'b10000) begin
            errors++;
            $display("FAIL mid_reset: got %b required 10000", {cs, mosi, dc_o, fbit, fbyte});
        end
        rst = 1'b0; start = 1'b0;
        tick();
        first = 8'h96;
        data = 64'hFFFF_FFFF_FFFF_FF96; dc = 8'hFE; n_tx = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if ({cs, mosi, dc_o, fbyte} !== {1'b0, first[7 - c], 1'b0, c == 7}) begin
                errors++;
                $display("FAIL restart cycle %0d: got cs,mosi,dc,fB=%b required %b",
                         c, {cs, mosi, dc_o, fbyte}, {1'b0, first[7 - c], 1'b0, c == 7});
            end
            tick();
        end
        checks++;
        if (cs !== 1'b1) begin
            errors++;
            $display("FAIL restart_end_cs: got %b required 1", cs);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_burst8();
        test_back_to_back();
        test_gap_two_bytes();
        test_zero_and_clamp();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
